intc_intr_cap: RTL and testbench

//  Parametrised normal-interrupt capture for the INTC core, successor to the fixed edge/level capture stage.

---
 rtl/intc_intr_cap.sv | 198 +++++++++++++++++++
 tb/tb_intc_intr_cap.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intc_intr_cap.sv
// rtl/intc_intr_cap.sv - normal-interrupt capture: sync, glitch filter, edge/level detect, pending and overflow
//
// Purpose:
//   Per-channel capture of raw asynchronous peripheral interrupt lines for the
//   INTC core. Each channel is synchronised, optionally glitch filtered, then
//   turned into a pending request by edge (rising/falling/both) or level
//   (active-high/active-low) detection. Software set, pending clear and CPU
//   acknowledge act on the pending bit. Edge-mode channels record a sticky
//   overflow flag when a new event arrives while a request is still pending.
//
// Ports:
//   clk          in   1       clock, all flops rising edge
//   rst_n        in   1       synchronous reset, active-low
//   intreq_i     in   INT_DW  raw interrupt inputs (asynchronous)
//   rg_ie_i      in   INT_DW  channel enable
//   rg_idt_i     in   INT_DW  detect mode: 1 edge, 0 level
//   rg_ipol_i    in   INT_DW  polarity: 0 high/rising, 1 low/falling
//   rg_ibe_i     in   INT_DW  both-edge enable (edge mode)
//   rg_flten_i   in   INT_DW  glitch filter enable
//   rg_fltthr_i  in   FLT_W   global filter threshold N
//   rg_sint_i    in   INT_DW  software interrupt set pulse
//   rg_irqc_i    in   INT_DW  pending clear pulse
//   cp_intack_i  in   INT_DW  CPU acknowledge
//   rg_ovfc_i    in   INT_DW  overflow flag clear
//   in_intreq_o  out  INT_DW  pending interrupt request
//   in_irq_o     out  INT_DW  copy of in_intreq_o
//   in_any_o     out  1       OR of all pending requests
//   in_ovf_o     out  INT_DW  sticky overflow flags

module intc_intr_cap #(
    parameter int INT_DW   = 192,
    parameter int SYNC_STG = 2,
    parameter int FLT_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INT_DW-1:0] intreq_i,
    input  logic [INT_DW-1:0] rg_ie_i,
    input  logic [INT_DW-1:0] rg_idt_i,
    input  logic [INT_DW-1:0] rg_ipol_i,
    input  logic [INT_DW-1:0] rg_ibe_i,
    input  logic [INT_DW-1:0] rg_flten_i,
    input  logic [FLT_W-1:0]  rg_fltthr_i,
    input  logic [INT_DW-1:0] rg_sint_i,
    input  logic [INT_DW-1:0] rg_irqc_i,
    input  logic [INT_DW-1:0] cp_intack_i,
    input  logic [INT_DW-1:0] rg_ovfc_i,
    output logic [INT_DW-1:0] in_intreq_o,
    output logic [INT_DW-1:0] in_irq_o,
    output logic              in_any_o,
    output logic [INT_DW-1:0] in_ovf_o
);

    // The arm counter must cover the time needed for a post-reset input
    // level to propagate through the sync chain, f and f_d.
    localparam int              ARM_W   = $clog2(SYNC_STG + 3);
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STG + 2);

    // ------------------------------------------------------------------
    // Input synchroniser: plain flop chain, nothing between stages
    // ------------------------------------------------------------------
    logic [INT_DW-1:0] r_sync [SYNC_STG];
    logic [INT_DW-1:0] w_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STG; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= intreq_i;
            for (int k = 1; k < SYNC_STG; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STG-1];

    // ------------------------------------------------------------------
    // Glitch filter: f follows s only after s has differed from f for
    // N+1 consecutive cycles. Using >= keeps the counter from running
    // away when the threshold is lowered below the current count; the
    // update then happens on the next cycle instead of wrapping.
    // ------------------------------------------------------------------
    logic [INT_DW-1:0] r_f;
    logic [INT_DW-1:0] r_fd;
    logic [FLT_W-1:0]  r_cnt [INT_DW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_f <= '0;
            for (int i = 0; i < INT_DW; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < INT_DW; i++) begin
                if (!rg_flten_i[i]) begin
                    r_f[i]   <= w_s[i];
                    r_cnt[i] <= '0;
                end else if (w_s[i] == r_f[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] >= rg_fltthr_i) begin
                    r_f[i]   <= w_s[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fd <= '0;
        end else begin
            r_fd <= r_f;
        end
    end

    // ------------------------------------------------------------------
    // Arm counter: suppresses edge/level events until reset-value flush
    // through the pipeline is complete, so lines already asserted at
    // reset release never look like a fresh edge.
    // ------------------------------------------------------------------
    logic [ARM_W-1:0] r_arm;
    logic             w_armed;

    assign w_armed = (r_arm == ARM_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_arm <= '0;
        end else if (!w_armed) begin
            r_arm <= r_arm + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------
    logic [INT_DW-1:0] w_rise;
    logic [INT_DW-1:0] w_fall;
    logic [INT_DW-1:0] w_act;
    logic [INT_DW-1:0] w_edge;
    logic [INT_DW-1:0] w_edge_a;
    logic [INT_DW-1:0] w_act_a;
    logic [INT_DW-1:0] w_clr;

    assign w_rise   = r_f & ~r_fd;
    assign w_fall   = ~r_f & r_fd;
    assign w_act    = r_f ^ rg_ipol_i;
    // Both-edge overrides polarity selection.
    assign w_edge   = (rg_ibe_i & (w_rise | w_fall))
                    | (~rg_ibe_i & ((rg_ipol_i & w_fall) | (~rg_ipol_i & w_rise)));
    assign w_edge_a = w_edge & {INT_DW{w_armed}};
    assign w_act_a  = w_act  & {INT_DW{w_armed}};
    assign w_clr    = rg_irqc_i | cp_intack_i;

    // ------------------------------------------------------------------
    // Pending and overflow. Set terms are ORed after the clear mask so a
    // new event coinciding with clear/ack keeps the request.
    // ------------------------------------------------------------------
    logic [INT_DW-1:0] r_pend;
    logic [INT_DW-1:0] r_ovf;
    logic              r_any;
    logic [INT_DW-1:0] w_pend_edge;
    logic [INT_DW-1:0] w_pend_lvl;
    logic [INT_DW-1:0] w_pend_nxt;
    logic [INT_DW-1:0] w_ovf_set;
    logic [INT_DW-1:0] w_ovf_nxt;

    assign w_pend_edge = (r_pend & ~w_clr) | w_edge_a | rg_sint_i;
    assign w_pend_lvl  = w_act_a | rg_sint_i;
    assign w_pend_nxt  = rg_ie_i & ((rg_idt_i & w_pend_edge) | (~rg_idt_i & w_pend_lvl));

    // Overflow: an edge-mode event lands on a request nobody has taken yet.
    assign w_ovf_set   = rg_idt_i & rg_ie_i & (w_edge_a | rg_sint_i) & r_pend & ~w_clr;
    assign w_ovf_nxt   = w_ovf_set | (r_ovf & ~rg_ovfc_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_ovf  <= '0;
            r_any  <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_ovf  <= w_ovf_nxt;
            r_any  <= |w_pend_nxt;
        end
    end

    assign in_intreq_o = r_pend;
    assign in_irq_o    = r_pend;
    assign in_any_o    = r_any;
    assign in_ovf_o    = r_ovf;

endmodule

// File: tb/tb_intc_intr_cap.sv
// tb/tb_intc_intr_cap.sv - self-checking bench for intc_intr_cap with behavioural reference model
module tb_intc_intr_cap;

    localparam int DW  = 192;
    localparam int SS  = 2;
    localparam int FW  = 4;
    localparam int SAT = SS + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [DW-1:0] intreq, ie, idt, ipol, ibe, flten, sint, irqc, ack, ovfc;
    logic [FW-1:0] thr;
    logic [DW-1:0] o_req, o_irq, o_ovf;
    logic          o_any;

    intc_intr_cap #(.INT_DW(DW), .SYNC_STG(SS), .FLT_W(FW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .intreq_i    (intreq),
        .rg_ie_i     (ie),
        .rg_idt_i    (idt),
        .rg_ipol_i   (ipol),
        .rg_ibe_i    (ibe),
        .rg_flten_i  (flten),
        .rg_fltthr_i (thr),
        .rg_sint_i   (sint),
        .rg_irqc_i   (irqc),
        .cp_intack_i (ack),
        .rg_ovfc_i   (ovfc),
        .in_intreq_o (o_req),
        .in_irq_o    (o_irq),
        .in_any_o    (o_any),
        .in_ovf_o    (o_ovf)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: input history queue, per-channel disagreement run
    // length, and a "cycles since reset release" age for arming.
    logic [DW-1:0] m_hist [$];
    logic [DW-1:0] m_f, m_fd, m_pend, m_ovf;
    logic          m_any;
    int            m_cnt [DW];
    int            m_age;

    task automatic model_edge();
        logic [DW-1:0] s, nf, npend, novf;
        bit armed;
        if (!rst_n) begin
            m_hist = {};
            repeat (SS) m_hist.push_back('0);
            m_f = '0; m_fd = '0; m_pend = '0; m_ovf = '0; m_any = 1'b0;
            for (int i = 0; i < DW; i++) m_cnt[i] = 0;
            m_age = 0;
            return;
        end
        s     = m_hist[0];
        armed = (m_age >= SAT);
        nf    = m_f;
        npend = '0;
        novf  = m_ovf;
        for (int i = 0; i < DW; i++) begin
            bit rs, fl, ev, act, clr, evt;
            if (!flten[i]) begin
                nf[i] = s[i]; m_cnt[i] = 0;
            end else if (s[i] == m_f[i]) begin
                m_cnt[i] = 0;
            end else if (m_cnt[i] >= int'(thr)) begin
                nf[i] = s[i]; m_cnt[i] = 0;
            end else begin
                m_cnt[i]++;
            end
            rs  = m_f[i] && !m_fd[i];
            fl  = !m_f[i] && m_fd[i];
            act = m_f[i] ^ ipol[i];
            if (ibe[i])       ev = rs || fl;
            else if (ipol[i]) ev = fl;
            else              ev = rs;
            clr = irqc[i] || ack[i];
            evt = (ev && armed) || sint[i];
            if (!ie[i])      npend[i] = 1'b0;
            else if (idt[i]) npend[i] = (m_pend[i] && !clr) || evt;
            else             npend[i] = (act && armed) || sint[i];
            if (idt[i] && ie[i] && m_pend[i] && !clr && evt) novf[i] = 1'b1;
            else if (ovfc[i])                                novf[i] = 1'b0;
        end
        m_fd   = m_f;
        m_f    = nf;
        m_pend = npend;
        m_ovf  = novf;
        m_any  = |npend;
        m_hist.push_back(intreq);
        void'(m_hist.pop_front());
        if (m_age < SAT) m_age++;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("req", o_req, m_pend);
        chk("irq", o_irq, m_pend);
        chk("any", DW'(o_any), DW'(m_any));
        chk("ovf", o_ovf, m_ovf);
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    logic [DW-1:0] mask5;

    initial begin
        rst_n = 1'b0; intreq = '0; sint = '0; irqc = '0; ack = '0; ovfc = '0;
        ie = '1; idt = '1; ipol = '0; ibe = '0; flten = '0; thr = 4'd3;
        idt[3] = 1'b0; ipol[3] = 1'b1; ibe[2] = 1'b1; flten[1] = 1'b1;
        // keep inputs busy during reset to show reset wins
        intreq = rnd();
        repeat (2) cyc();
        chk("rst_req", o_req, '0);
        chk("rst_ovf", o_ovf, '0);
        chk("rst_any", DW'(o_any), '0);
        intreq = '0;
        rst_n  = 1'b1;
        repeat (6) cyc();

        // ch0 rising edge latency, ack
        intreq[0] = 1'b1;
        repeat (3) cyc();
        chk("ch0_lat3", DW'(o_req[0]), DW'(0));
        cyc();
        chk("ch0_lat4", DW'(o_req[0]), DW'(1));
        chk("ch0_any", DW'(o_any), DW'(1));
        ack[0] = 1'b1; cyc(); ack[0] = 1'b0;
        chk("ch0_ack", DW'(o_req[0]), DW'(0));

        // ch1 filter N=3: 3-cycle pulse dropped, 4-cycle pulse passes at cycle 7
        intreq[1] = 1'b1; repeat (3) cyc(); intreq[1] = 1'b0;
        repeat (8) cyc();
        chk("ch1_short", DW'(o_req[1]), DW'(0));
        intreq[1] = 1'b1; repeat (4) cyc(); intreq[1] = 1'b0;
        repeat (2) cyc();
        chk("ch1_lat6", DW'(o_req[1]), DW'(0));
        cyc();
        chk("ch1_lat7", DW'(o_req[1]), DW'(1));
        ack[1] = 1'b1; cyc(); ack[1] = 1'b0;
        repeat (6) cyc();

        // ch2 both-edge
        intreq[2] = 1'b1; repeat (4) cyc();
        chk("ch2_rise", DW'(o_req[2]), DW'(1));
        ack[2] = 1'b1; cyc(); ack[2] = 1'b0;
        chk("ch2_ack", DW'(o_req[2]), DW'(0));
        intreq[2] = 1'b0; repeat (4) cyc();
        chk("ch2_fall", DW'(o_req[2]), DW'(1));
        ack[2] = 1'b1; cyc(); ack[2] = 1'b0;

        // ch3 active-low level
        chk("ch3_low", DW'(o_req[3]), DW'(1));
        intreq[3] = 1'b1; repeat (3) cyc();
        chk("ch3_rel3", DW'(o_req[3]), DW'(1));
        cyc();
        chk("ch3_rel4", DW'(o_req[3]), DW'(0));

        // ch4 overflow, set-wins, overflow clear
        intreq[4] = 1'b1; repeat (4) cyc();
        chk("ch4_pend", DW'(o_req[4]), DW'(1));
        intreq[4] = 1'b0; repeat (4) cyc();
        intreq[4] = 1'b1; repeat (4) cyc();
        chk("ch4_ovf", DW'(o_ovf[4]), DW'(1));
        intreq[4] = 1'b0; repeat (4) cyc();
        intreq[4] = 1'b1; repeat (3) cyc();
        irqc[4] = 1'b1; cyc(); irqc[4] = 1'b0;
        chk("ch4_setwins", DW'(o_req[4]), DW'(1));
        ovfc[4] = 1'b1; cyc(); ovfc[4] = 1'b0;
        chk("ch4_ovfc", DW'(o_ovf[4]), DW'(0));
        ack[4] = 1'b1; cyc(); ack[4] = 1'b0;

        // ch6 enable drop
        sint[6] = 1'b1; cyc(); sint[6] = 1'b0;
        chk("ch6_sint", DW'(o_req[6]), DW'(1));
        ie[6] = 1'b0; cyc();
        chk("ch6_iedrop", DW'(o_req[6]), DW'(0));
        ie[6] = 1'b1; repeat (2) cyc();
        chk("ch6_reen", DW'(o_req[6]), DW'(0));

        // reset in the middle of a filter count
        thr = 4'd5;
        intreq[1] = 1'b1; repeat (4) cyc();
        rst_n = 1'b0; cyc();
        chk("rstmid_req", o_req, '0);
        chk("rstmid_ovf", o_ovf, '0);
        rst_n = 1'b1;
        intreq[1] = 1'b0;
        repeat (8) cyc();

        // reset with all lines high: no spurious request; SW set during arm
        intreq = '1; idt = '1; ipol = rnd(); ibe = rnd(); flten = '0; ie = '1;
        rst_n = 1'b0; repeat (2) cyc();
        rst_n = 1'b1; cyc();
        sint[5] = 1'b1; cyc(); sint[5] = 1'b0;
        chk("arm_sint", DW'(o_req[5]), DW'(1));
        repeat (10) cyc();
        mask5 = '1; mask5[5] = 1'b0;
        chk("arm_noreq", o_req & mask5, '0);
        chk("arm_noovf", o_ovf, '0);

        // randomized phase
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                idt   = rnd(); ipol = rnd(); ibe = rnd();
                flten = rnd(); ie   = rnd() | rnd();
                thr   = FW'($urandom_range(0, 4));
            end
            rst_n  = ($urandom_range(0, 299) != 0);
            intreq = intreq ^ (rnd() & rnd() & rnd());
            sint   = rnd() & rnd() & rnd() & rnd();
            irqc   = rnd() & rnd() & rnd() & rnd();
            ack    = rnd() & rnd() & rnd() & rnd();
            ovfc   = rnd() & rnd() & rnd() & rnd();
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
